// File: rtl/aes_inv_pkg.sv
// Shared AES decryption helpers: FSM state type, inverse S-box table, InvShiftRows indexing.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package aes_inv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // FIPS-197 inverse S-box; entry b is INV_SBOX[b] (index 0 is the leftmost byte).
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Source byte for output byte idx under InvShiftRows.
    // idx = r + 4c, so r = idx[1:0], c = idx[3:2]; source is r + 4*((c - r) mod 4).
    function automatic logic [3:0] inv_shift_src(input logic [3:0] idx);
        logic [1:0] row;
        logic [1:0] col;
        row = idx[1:0];
        col = idx[3:2];
        return {col - row, row};
    endfunction

    // Byte n of a state, byte 0 being the most significant.
    function automatic logic [7:0] get_byte(input logic [127:0] s, input logic [3:0] n);
        return s[8 * (15 - int'(n)) +: 8];
    endfunction

endpackage

// File: rtl/inv_sbox_lut.sv
// Single-byte inverse S-box lookup.
// Latency: combinational.
// Backpressure: none; pure function of the input byte.
module inv_sbox_lut (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    import aes_inv_pkg::*;

    assign out_byte = INV_SBOX[in_byte];

endmodule

// File: rtl/inv_shift_sub.sv
// Computes InvSubBytes(InvShiftRows(state)), BYTES_PER_CYCLE bytes per cycle.
// Latency: out_valid rises 16/BYTES_PER_CYCLE edges after the acceptance edge.
// Backpressure: result held in DONE until out_ready; in_ready only high in IDLE.
module inv_shift_sub #(
    parameter int BYTES_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    import aes_inv_pkg::*;

    if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4) begin : g_bad_bpc
        $error("inv_shift_sub: BYTES_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [4:0] STEP = 5'(BYTES_PER_CYCLE);

    state_t       state;
    logic [4:0]   cnt;
    logic [127:0] cap_state;
    logic [3:0]   wr_idx [BYTES_PER_CYCLE];
    logic [7:0]   sb_in  [BYTES_PER_CYCLE];
    logic [7:0]   sb_out [BYTES_PER_CYCLE];
    logic         last_beat;

    // Select the shifted source byte for each output byte written this cycle.
    always_comb begin
        for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
            wr_idx[k] = cnt[3:0] + 4'(k);
            sb_in[k]  = get_byte(cap_state, inv_shift_src(wr_idx[k]));
        end
    end

    // This beat writes byte 15 when the counter reaches 16 afterwards.
    assign last_beat = (cnt + STEP) == 5'd16;

    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_sbox
        inv_sbox_lut u_sbox (
            .in_byte  (sb_in[g]),
            .out_byte (sb_out[g])
        );
    end

    // Control FSM with registered handshake outputs and the byte-wise result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= 5'd0;
            cap_state <= '0;
            out_state <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        cap_state <= in_state;
                        cnt       <= 5'd0;
                        state     <= ST_RUN;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Unwritten bytes keep their old value; only DONE contents matter.
                    for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
                        out_state[8 * (15 - int'(wr_idx[k])) +: 8] <= sb_out[k];
                    end
                    cnt <= cnt + STEP;
                    if (last_beat) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // in_ready returns only after this edge, so no accept on the handshake edge.
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_shift_sub.sv
// Bench for inv_shift_sub: two instances (1 and 4 bytes per cycle) against a GF(2^8) derived model.
// Latency: checks exact result latency per instance.
// Backpressure: exercises out_ready stalls and in_valid held through a run.
module tb_inv_shift_sub;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid  [2];
    logic         in_ready  [2];
    logic [127:0] in_state  [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic [127:0] out_state [2];
    logic         busy      [2];

    int errors = 0;
    int checks = 0;
    logic [7:0] invs [256];

    always #5 clk = ~clk;

    inv_shift_sub #(.BYTES_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_state(in_state[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_state(out_state[0]),
        .busy(busy[0])
    );

    inv_shift_sub #(.BYTES_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_state(in_state[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_state(out_state[1]),
        .busy(busy[1])
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box from multiplicative inverse plus affine map, then inverted.
    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            invs[s] = 8'(a);
        end
    endtask

    // Byte at row r, column c moves to column (c + r) mod 4, then inverse substitution.
    function automatic logic [127:0] model(input logic [127:0] st);
        logic [7:0]   b [16];
        logic [127:0] o;
        int dest;
        o = '0;
        for (int i = 0; i < 16; i++) b[i] = st[127 - 8*i -: 8];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                dest = r + 4 * ((c + r) % 4);
                o[127 - 8*dest -: 8] = invs[b[r + 4*c]];
            end
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- check / drive helpers ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0; in_state[d] = '0; out_ready[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Present st; returns at the negedge just after the acceptance edge.
    task automatic accept(input int d, input logic [127:0] st);
        int w;
        w = 0;
        in_valid[d] = 1'b1;
        in_state[d] = st;
        while (in_ready[d] !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("accept_in_ready", 128'(in_ready[d]), 128'd1);
        @(negedge clk);
        in_valid[d] = 1'b0;
    endtask

    task automatic expect_result(input int d, input int lat, input logic [127:0] exp, input string tag);
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            if (i < lat) chk({tag, "_early_valid"}, 128'(out_valid[d]), 128'd0);
        end
        chk({tag, "_valid"},    128'(out_valid[d]), 128'd1);
        chk({tag, "_state"},    out_state[d], exp);
        chk({tag, "_busy"},     128'(busy[d]), 128'd1);
        chk({tag, "_in_ready"}, 128'(in_ready[d]), 128'd0);
    endtask

    task automatic drain(input int d, input string tag);
        out_ready[d] = 1'b1;
        @(negedge clk);
        out_ready[d] = 1'b0;
        chk({tag, "_drop_valid"}, 128'(out_valid[d]), 128'd0);
        chk({tag, "_idle_ready"}, 128'(in_ready[d]), 128'd1);
        chk({tag, "_idle_busy"},  128'(busy[d]), 128'd0);
    endtask

    // Random producer/consumer with a scoreboard; handshakes are resolved at each negedge.
    task automatic rand_stream(input int d, input int n, input string tag);
        logic [127:0] exp_q [$];
        int sent, recv, cyc;
        sent = 0; recv = 0; cyc = 0;
        in_valid[d] = 1'b0;
        out_ready[d] = 1'b0;
        while (recv < n && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (!in_valid[d] && sent < n && $urandom_range(3, 0) != 0) begin
                in_valid[d] = 1'b1;
                in_state[d] = rand128();
            end else if (in_valid[d] && $urandom_range(1, 0) == 0) begin
                in_state[d] = rand128();
            end
            out_ready[d] = ($urandom_range(2, 0) != 0);
            if (in_valid[d] && in_ready[d]) begin
                exp_q.push_back(model(in_state[d]));
                sent++;
            end
            if (out_valid[d] && out_ready[d]) begin
                if (exp_q.size() == 0) chk({tag, "_unexpected_out"}, 128'd1, 128'd0);
                else chk({tag, "_out_state"}, out_state[d], exp_q.pop_front());
                recv++;
            end
            // a state accepted at the coming edge must not be offered again
            if (in_valid[d] && in_ready[d]) begin
                @(negedge clk);
                cyc++;
                in_valid[d] = 1'b0;
                out_ready[d] = 1'b0;
                if (out_valid[d]) begin
                    chk({tag, "_late_valid"}, 128'd1, 128'd0);
                end
            end
        end
        in_valid[d] = 1'b0;
        out_ready[d] = 1'b0;
        chk({tag, "_recv_count"}, 128'(recv), 128'(n));
        chk({tag, "_queue_empty"}, 128'(exp_q.size()), 128'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0] a;
        logic [127:0] b;
        build_tables();
        do_reset();

        // reset state
        for (int d = 0; d < 2; d++) begin
            chk("rst_in_ready",  128'(in_ready[d]), 128'd1);
            chk("rst_out_valid", 128'(out_valid[d]), 128'd0);
            chk("rst_busy",      128'(busy[d]), 128'd0);
            chk("rst_out_state", out_state[d], 128'd0);
        end

        // FIPS-197 vector, 16 edges and 4 edges
        accept(0, 128'h7ad5fda789ef4e272bca100b3d9ff59f);
        expect_result(0, 16, 128'hbd6e7c3df2b5779e0b61216e8b10b689, "vec_b1");
        drain(0, "vec_b1");
        accept(1, 128'h7ad5fda789ef4e272bca100b3d9ff59f);
        expect_result(1, 4, 128'hbd6e7c3df2b5779e0b61216e8b10b689, "vec_b4");
        drain(1, "vec_b4");

        // uniform states
        accept(0, {16{8'h63}});
        expect_result(0, 16, 128'h0, "all63");
        drain(0, "all63");
        accept(0, 128'h0);
        expect_result(0, 16, {16{8'h52}}, "all00");
        drain(0, "all00");
        accept(1, {16{8'h63}});
        expect_result(1, 4, 128'h0, "all63_b4");
        drain(1, "all63_b4");

        // output stall for 10 cycles
        a = rand128();
        accept(0, a);
        expect_result(0, 16, model(a), "stall");
        b = out_state[0];
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_valid",    128'(out_valid[0]), 128'd1);
            chk("stall_state",    out_state[0], model(a));
            chk("stall_in_ready", 128'(in_ready[0]), 128'd0);
        end
        drain(0, "stall");
        repeat (3) @(negedge clk);
        chk("stall_single_transfer", 128'(out_valid[0]), 128'd0);

        // reset in the middle of a run (cnt = 7)
        accept(0, rand128());
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready",  128'(in_ready[0]), 128'd1);
        chk("abort_out_valid", 128'(out_valid[0]), 128'd0);
        chk("abort_busy",      128'(busy[0]), 128'd0);
        chk("abort_out_state", out_state[0], 128'd0);
        repeat (20) @(negedge clk);
        chk("abort_no_valid", 128'(out_valid[0]), 128'd0);
        a = rand128();
        accept(0, a);
        expect_result(0, 16, model(a), "after_abort");
        drain(0, "after_abort");

        // reset wins over a simultaneous in_valid
        in_valid[0] = 1'b1;
        in_state[0] = rand128();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid[0] = 1'b0;
        chk("rst_over_valid_busy", 128'(busy[0]), 128'd0);
        repeat (2) @(negedge clk);
        chk("rst_over_valid_idle", 128'(busy[0]), 128'd0);

        // in_valid held high with changing in_state through a whole run
        a = rand128();
        in_valid[0] = 1'b1;
        in_state[0] = a;
        @(negedge clk);
        for (int i = 1; i <= 16; i++) begin
            in_state[0] = rand128();
            @(negedge clk);
            chk("hold_in_ready", 128'(in_ready[0]), 128'd0);
        end
        chk("hold_valid", 128'(out_valid[0]), 128'd1);
        chk("hold_state", out_state[0], model(a));
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        in_valid[0] = 1'b0;
        chk("hold_no_accept_on_handshake", 128'(busy[0]), 128'd0);
        chk("hold_ready_back", 128'(in_ready[0]), 128'd1);
        chk("hold_valid_drop", 128'(out_valid[0]), 128'd0);
        @(negedge clk);

        // random streams
        rand_stream(0, 100, "rand_b1");
        rand_stream(1, 30, "rand_b4");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
